pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS fetch stage: holds the fetch address, advances it by a fixed increment, accepts branch/jump redirects, and obeys pipeline stall and halt. Adds a debug run/halt/step state machine driven by the debug unit, plus saturating cycle and fetch counters for the debug readout. Sits between the branch/hazard logic and instruction memory, and replaces the fixed-width PC register.

---
 rtl/pc_unit.sv | 108 ++++++++++
 tb/tb_pc_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter for the MIPS fetch stage with a debug run/halt/step FSM and saturating counters.
// Optional single-step support is compiled in when PC_STEP_EN is defined.
module pc_unit #(
   parameter int                ADDR_W       = 32,
   parameter int                CNT_W        = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter int                INC          = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_stall,
   input  logic              i_halt,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_addr,
   input  logic              i_resume,
   input  logic              i_step,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_running,
   output logic              o_halted,
   output logic [CNT_W-1:0]  o_cycle_count,
   output logic [CNT_W-1:0]  o_fetch_count
);

   typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_STEP} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [CNT_W-1:0]  fetch_q, fetch_d;
   logic              running_q, halted_q;
   logic              in_halted;
   logic              do_update;

`ifndef PC_STEP_EN
   // Step request has no effect in this build; keep the port quiet.
   logic unused_step;
   assign unused_step = i_step;
`endif

   always_comb begin
      in_halted = (state_q == ST_HALTED);
      // Halt beats redirect, redirect beats stall.
      do_update = !in_halted && !i_halt && (i_redirect || !i_stall);
      pc_d      = i_redirect ? i_redirect_addr : pc_q + ADDR_W'(INC);
      cycle_d   = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
      fetch_d   = (fetch_q == '1) ? fetch_q : fetch_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_RUN;
         pc_q      <= RESET_VECTOR;
         cycle_q   <= '0;
         fetch_q   <= '0;
         running_q <= 1'b1;
         halted_q  <= 1'b0;
      end else begin
         if (!in_halted) cycle_q <= cycle_d;
         if (do_update) begin
            pc_q    <= pc_d;
            fetch_q <= fetch_d;
         end
         case (state_q)
            ST_RUN: begin
               if (i_halt) begin
                  state_q   <= ST_HALTED;
                  running_q <= 1'b0;
                  halted_q  <= 1'b1;
               end
            end
            ST_STEP: begin
               // One update (or a halt) ends the step.
               if (i_halt || do_update) begin
                  state_q   <= ST_HALTED;
                  running_q <= 1'b0;
                  halted_q  <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (i_resume) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
                  halted_q  <= 1'b0;
               end
`ifdef PC_STEP_EN
               else if (i_step) begin
                  state_q   <= ST_STEP;
                  running_q <= 1'b1;
                  halted_q  <= 1'b0;
               end
`endif
            end
            default: begin
               state_q   <= ST_HALTED;
               running_q <= 1'b0;
               halted_q  <= 1'b1;
            end
         endcase
      end
   end

   assign o_pc          = pc_q;
   assign o_running     = running_q;
   assign o_halted      = halted_q;
   assign o_cycle_count = cycle_q;
   assign o_fetch_count = fetch_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a default instance and a narrow one (8-bit PC, 3-bit counters) share stimulus
// and are compared every cycle against a behavioural model.
module tb_pc_unit;

`ifdef PC_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, stall, halt, redirect, resume, step;
   logic [31:0] raddr;

   logic [31:0] a_pc, a_cyc, a_fet;
   logic        a_run, a_hlt;
   logic [7:0]  b_pc;
   logic [2:0]  b_cyc, b_fet;
   logic        b_run, b_hlt;

   pc_unit u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_halt(halt),
      .i_redirect(redirect), .i_redirect_addr(raddr), .i_resume(resume), .i_step(step),
      .o_pc(a_pc), .o_running(a_run), .o_halted(a_hlt),
      .o_cycle_count(a_cyc), .o_fetch_count(a_fet)
   );

   pc_unit #(.ADDR_W(8), .CNT_W(3), .RESET_VECTOR(8'hF8), .INC(4)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_halt(halt),
      .i_redirect(redirect), .i_redirect_addr(raddr[7:0]), .i_resume(resume), .i_step(step),
      .o_pc(b_pc), .o_running(b_run), .o_halted(b_hlt),
      .o_cycle_count(b_cyc), .o_fetch_count(b_fet)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: index 0 = default instance, 1 = narrow instance.
   longint unsigned m_pc[2], m_cyc[2], m_fet[2];
   string           m_mode[2];

   function automatic longint unsigned pc_mod(int k);
      return (k == 0) ? 64'h1_0000_0000 : 64'h100;
   endfunction

   function automatic longint unsigned cnt_max(int k);
      return (k == 0) ? 64'hFFFF_FFFF : 64'd7;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k]   = (k == 0) ? 64'h0 : 64'hF8;
         m_cyc[k]  = 0;
         m_fet[k]  = 0;
         m_mode[k] = "RUN";
      end
   endtask

   task automatic model_tick();
      for (int k = 0; k < 2; k++) begin
         if (m_mode[k] == "HALTED") begin
            if (resume) m_mode[k] = "RUN";
            else if (step && STEP_EN) m_mode[k] = "STEP";
         end else begin
            if (m_cyc[k] < cnt_max(k)) m_cyc[k] = m_cyc[k] + 1;
            if (halt) m_mode[k] = "HALTED";
            else if (redirect || !stall) begin
               if (redirect) m_pc[k] = longint'(raddr) % pc_mod(k);
               else          m_pc[k] = (m_pc[k] + 4) % pc_mod(k);
               if (m_fet[k] < cnt_max(k)) m_fet[k] = m_fet[k] + 1;
               if (m_mode[k] == "STEP") m_mode[k] = "HALTED";
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("a_pc",      64'(a_pc),  m_pc[0]);
      check("a_running", 64'(a_run), 64'(m_mode[0] != "HALTED"));
      check("a_halted",  64'(a_hlt), 64'(m_mode[0] == "HALTED"));
      check("a_cycle",   64'(a_cyc), m_cyc[0]);
      check("a_fetch",   64'(a_fet), m_fet[0]);
      check("b_pc",      64'(b_pc),  m_pc[1]);
      check("b_running", 64'(b_run), 64'(m_mode[1] != "HALTED"));
      check("b_halted",  64'(b_hlt), 64'(m_mode[1] == "HALTED"));
      check("b_cycle",   64'(b_cyc), m_cyc[1]);
      check("b_fetch",   64'(b_fet), m_fet[1]);
   endtask

   task automatic drive(input logic st, input logic hl, input logic rd, input logic [31:0] ad,
                        input logic rs, input logic sp);
      stall = st; halt = hl; redirect = rd; raddr = ad; resume = rs; step = sp;
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
      #1;
      check_all();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint unsigned p;
      rst_n = 1'b0;
      drive(0, 0, 0, 32'h0, 0, 0);
      model_reset();
      #12;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Free run, including wrap of the narrow instance.
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("a_pc_free", 64'(a_pc), 64'(4 * i));
         check("b_pc_wrap", 64'(b_pc), 64'((8'hF8 + 4 * i) & 8'hFF));
      end
      check("a_fetch_5", 64'(a_fet), 64'd5);
      check("a_cycle_5", 64'(a_cyc), 64'd5);

      // Redirect beats stall.
      drive(1, 0, 0, 32'h0, 0, 0);  tick(); check("stall_hold", 64'(a_pc), 64'h14);
      drive(1, 0, 1, 32'h40, 0, 0); tick(); check("redir_in_stall", 64'(a_pc), 64'h40);
      drive(1, 0, 0, 32'h0, 0, 0);  tick(); check("stall_after_redir", 64'(a_pc), 64'h40);
      drive(0, 0, 0, 32'h0, 0, 0);  tick(); check("resume_adv", 64'(a_pc), 64'h44);

      // Halt beats redirect; halted ignores pipeline inputs.
      drive(0, 1, 1, 32'h80, 0, 0); tick();
      check("halt_flag", 64'(a_hlt), 64'd1);
      check("halt_pc", 64'(a_pc), 64'h44);
      check("halt_cycle", 64'(a_cyc), 64'd10);
      for (int i = 0; i < 10; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, 0, 0);
         tick();
      end
      check("halted_cycle_frozen", 64'(a_cyc), 64'd10);
      check("halted_pc_frozen", 64'(a_pc), 64'h44);
      check("b_cycle_sat", 64'(b_cyc), 64'd7);
      drive(0, 0, 0, 32'h0, 1, 0); tick();
      check("resume_running", 64'(a_run), 64'd1);
      check("resume_pc_same", 64'(a_pc), 64'h44);
      drive(0, 0, 0, 32'h0, 0, 0); tick();
      check("resume_first_adv", 64'(a_pc), 64'h48);

      // Single-step pulses from a halt at 0x48.
      drive(0, 1, 0, 32'h0, 0, 0); tick();
      check("halt2_pc", 64'(a_pc), 64'h48);
      for (int j = 1; j <= 3; j++) begin
         drive(0, 0, 0, 32'h0, 0, 1); tick();
         drive(0, 0, 0, 32'h0, 0, 0); tick(); tick(); tick();
         p = STEP_EN ? 64'(32'h48 + 4 * j) : 64'h48;
         check("step_pc", 64'(a_pc), p);
         check("step_rehalted", 64'(a_hlt), 64'd1);
      end
      drive(1, 0, 0, 32'h0, 0, 1); tick();
      drive(1, 0, 0, 32'h0, 0, 0); tick(); tick();
      check("step_stalled_running", 64'(a_run), 64'(STEP_EN));
      check("step_stalled_pc", 64'(a_pc), p);
      drive(0, 0, 0, 32'h0, 0, 0); tick();
      check("step_after_stall_pc", 64'(a_pc), STEP_EN ? p + 4 : p);
      check("step_after_stall_halted", 64'(a_hlt), 64'd1);

      // Asynchronous reset between edges while stepping.
      drive(1, 0, 0, 32'h0, 0, 1); tick();
      drive(1, 0, 0, 32'h0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      check("rst_async_pc", 64'(a_pc), 64'h0);
      check("rst_async_bpc", 64'(b_pc), 64'hF8);
      check("rst_async_running", 64'(a_run), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 5) == 0), $urandom,
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
